rvb_full_arbiter: RTL and testbench
===================================

RVB_FULL_ARBITER -- requirements
Module: rvb_full_arbiter

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, which sets the operand and result width.
REQ-002 The module SHALL have parameter DEPTH, default 4, which sets the maximum number of operations in flight in the shared core (power of two, 2..16).
REQ-003 The module SHALL use a single clock domain and an asynchronous, active-low reset.
REQ-004 The module SHALL have the following ports, clock and reset first:
- clock  in  1  positive-edge clock
- resetn  in  1  asynchronous active-low reset
- a_din_valid / b_din_valid  in  1  requester A/B has an operation
- a_din_ready / b_din_ready  out  1  operation accepted
- a_din_rs1 / b_din_rs1  in  XLEN  1st operand
- a_din_rs2 / b_din_rs2  in  XLEN  2nd operand
- a_din_rs3 / b_din_rs3  in  XLEN  3rd operand
- a_din_insn / b_din_insn  in  32  instruction word
- a_dout_valid / b_dout_valid  out  1  result for A/B valid
- a_dout_ready / b_dout_ready  in  1  A/B accepts result
- a_dout_rd / b_dout_rd  out  XLEN  result value
- core_din_valid  out  1  operation to shared bitmanip core
- core_din_ready  in  1  core accepts operation
- core_din_rs1, core_din_rs2, core_din_rs3  out  XLEN  operands to core
- core_din_insn  out  32  instruction to core
- core_dout_valid  in  1  core result valid (core returns in issue order)
- core_dout_ready  out  1  result accepted from core
- core_dout_rd  in  XLEN  core result
- err  out  1  sticky protocol error

Function
REQ-005 A transfer SHALL occur on any valid/ready pair only in a cycle where both are high at the rising clock edge.
REQ-006 The arbiter SHALL keep a registered count of in-flight operations (0..DEPTH); the arbiter is full when count==DEPTH.
REQ-007 Arbitration when unlocked and not full:
- only one requester valid: that requester is selected;
- both valid: the requester named by the registered priority pointer (A after reset) is selected.
REQ-008 core_din_valid SHALL equal (selected requester valid AND not full); core operand and insn outputs SHALL be muxed combinationally from the selected requester.
REQ-009 Lock: if core_din_valid is high and core_din_ready is low, the arbiter SHALL set a lock register holding the selection; while locked the selection SHALL NOT change; the lock clears on the core_din handshake.
REQ-010 The selected requester's din_ready SHALL equal (core_din_ready AND not full); the unselected requester's din_ready SHALL be 0.
REQ-011 On each core_din handshake, the priority pointer SHALL move to the requester that was not granted.
REQ-012 On each core_din handshake, the granted requester ID SHALL be pushed into a DEPTH-entry tag FIFO and count SHALL increment.
REQ-013 A push SHALL never occur while full, even if a pop happens in the same cycle; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-014 Return path when count>0:
- x_dout_valid = core_dout_valid for the requester x named by the head tag; 0 for the other requester;
- core_dout_ready = the head requester's dout_ready.
REQ-015 Both a_dout_rd and b_dout_rd SHALL carry core_dout_rd unmodified.
REQ-016 A core_dout handshake SHALL pop the tag FIFO and decrement count.
REQ-017 Issue latency SHALL be 0 cycles (combinational pass-through), and return latency SHALL be 0 cycles (combinational pass-through).
REQ-018 When count==0, core_dout_ready SHALL be 0, both dout_valid outputs SHALL be 0, and core_dout_valid high SHALL set err.
REQ-019 err SHALL stay at 1 until reset.
REQ-020 FIFO read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-021 While resetn is low, the arbiter SHALL clear count, both FIFO pointers, the lock and err, and SHALL set the priority pointer to A.
REQ-022 While resetn is low, all outputs SHALL be driven 0.
REQ-023 If reset is asserted mid-operation, all in-flight tags SHALL be discarded with no replay.
REQ-024 After resetn deasserts, the arbiter SHALL resume normal operation at the first clock edge.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- A and B both valid continuously, core_din_ready=1, core returns immediately -> grants alternate A,B,A,B; each result is routed to its own requester.
- B valid alone with core_din_ready=0 for 3 cycles, A becomes valid in cycle 2 -> selection stays B and core_din_insn is stable until the handshake; A is granted next.
- DEPTH=4, 4 issues with no core results -> count=4 and both din_ready=0; one pop then lets exactly one new issue.
- Push and pop in the same cycle at count=2 -> count stays 2; the FIFO head advances correctly.
- core_dout_valid=1 with count=0 -> err=1 and stays 1; core_dout_ready=0.
- resetn pulsed low with count=3 -> all outputs 0 and count=0; the next grant with both requesters valid goes to A.

Source files
------------

// File: rtl/rvb_full_arbiter.sv
// Two-requester front end for a shared bitmanip core.
// Requests are arbitrated onto the core's input channel. A tag FIFO records
// which requester owns each in-flight operation, so in-order core results
// can be routed back to the right requester. Both directions are
// combinational pass-through, so neither path adds latency.
module rvb_full_arbiter #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            a_din_valid,
  output logic            a_din_ready,
  input  logic [XLEN-1:0] a_din_rs1,
  input  logic [XLEN-1:0] a_din_rs2,
  input  logic [XLEN-1:0] a_din_rs3,
  input  logic [31:0]     a_din_insn,
  output logic            a_dout_valid,
  input  logic            a_dout_ready,
  output logic [XLEN-1:0] a_dout_rd,
  input  logic            b_din_valid,
  output logic            b_din_ready,
  input  logic [XLEN-1:0] b_din_rs1,
  input  logic [XLEN-1:0] b_din_rs2,
  input  logic [XLEN-1:0] b_din_rs3,
  input  logic [31:0]     b_din_insn,
  output logic            b_dout_valid,
  input  logic            b_dout_ready,
  output logic [XLEN-1:0] b_dout_rd,
  output logic            core_din_valid,
  input  logic            core_din_ready,
  output logic [XLEN-1:0] core_din_rs1,
  output logic [XLEN-1:0] core_din_rs2,
  output logic [XLEN-1:0] core_din_rs3,
  output logic [31:0]     core_din_insn,
  input  logic            core_dout_valid,
  output logic            core_dout_ready,
  input  logic [XLEN-1:0] core_dout_rd,
  output logic            err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Requester IDs: 0 = A, 1 = B.
  logic [CW-1:0] count;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          locked;
  logic          lock_sel;
  logic          prio;
  logic          err_q;
  logic          tags [DEPTH];

  logic sel;
  logic sel_valid;
  logic full;
  logic nonempty;
  logic head;
  logic head_ready;
  logic push;
  logic pop;

  // Selection: a held (locked) grant wins, then a lone requester, then the priority pointer.
  always_comb begin
    sel = prio;
    if (locked)
      sel = lock_sel;
    else if (a_din_valid && !b_din_valid)
      sel = 1'b0;
    else if (b_din_valid && !a_din_valid)
      sel = 1'b1;
  end

  assign full      = (count == CW'(DEPTH));
  assign nonempty  = (count != '0);
  assign sel_valid = sel ? b_din_valid : a_din_valid;

  // Issue path: every output is forced low while reset is held.
  assign core_din_valid = resetn & sel_valid & ~full;
  assign core_din_rs1   = !resetn ? '0 : (sel ? b_din_rs1  : a_din_rs1);
  assign core_din_rs2   = !resetn ? '0 : (sel ? b_din_rs2  : a_din_rs2);
  assign core_din_rs3   = !resetn ? '0 : (sel ? b_din_rs3  : a_din_rs3);
  assign core_din_insn  = !resetn ? '0 : (sel ? b_din_insn : a_din_insn);
  assign a_din_ready    = resetn & ~sel & core_din_ready & ~full;
  assign b_din_ready    = resetn &  sel & core_din_ready & ~full;
  assign push           = core_din_valid & core_din_ready;

  // Return path: the head tag decides which requester sees the core result.
  assign head            = tags[rptr];
  assign head_ready      = head ? b_dout_ready : a_dout_ready;
  assign core_dout_ready = resetn & nonempty & head_ready;
  assign a_dout_valid    = resetn & nonempty & ~head & core_dout_valid;
  assign b_dout_valid    = resetn & nonempty &  head & core_dout_valid;
  assign a_dout_rd       = resetn ? core_dout_rd : '0;
  assign b_dout_rd       = resetn ? core_dout_rd : '0;
  assign pop             = core_dout_valid & core_dout_ready;
  assign err             = err_q;

  // Control state: occupancy, FIFO pointers, grant lock, priority and sticky error.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      locked   <= 1'b0;
      lock_sel <= 1'b0;
      prio     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        wptr   <= wptr + 1'b1;
        prio   <= ~sel;
        locked <= 1'b0;
      end else if (core_din_valid) begin
        locked   <= 1'b1;
        lock_sel <= sel;
      end
      if (pop)
        rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (core_dout_valid && !nonempty)
        err_q <= 1'b1;
    end
  end

  // Tag storage holds only data, so it needs no reset; the pointers define validity.
  always_ff @(posedge clock) begin
    if (push)
      tags[wptr] <= sel;
  end

endmodule

// File: tb/tb_rvb_full_arbiter.sv
// Bench for rvb_full_arbiter: directed scenarios plus a randomized phase.
// A queue-based reference model predicts every output on every cycle.
module tb_rvb_full_arbiter;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic            a_din_valid, a_din_ready, a_dout_valid, a_dout_ready;
  logic            b_din_valid, b_din_ready, b_dout_valid, b_dout_ready;
  logic [XLEN-1:0] a_din_rs1, a_din_rs2, a_din_rs3, a_dout_rd;
  logic [XLEN-1:0] b_din_rs1, b_din_rs2, b_din_rs3, b_dout_rd;
  logic [31:0]     a_din_insn, b_din_insn, core_din_insn;
  logic            core_din_valid, core_din_ready, core_dout_valid, core_dout_ready;
  logic [XLEN-1:0] core_din_rs1, core_din_rs2, core_din_rs3, core_dout_rd;
  logic            err;

  rvb_full_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn),
    .a_din_valid(a_din_valid), .a_din_ready(a_din_ready),
    .a_din_rs1(a_din_rs1), .a_din_rs2(a_din_rs2), .a_din_rs3(a_din_rs3),
    .a_din_insn(a_din_insn),
    .a_dout_valid(a_dout_valid), .a_dout_ready(a_dout_ready), .a_dout_rd(a_dout_rd),
    .b_din_valid(b_din_valid), .b_din_ready(b_din_ready),
    .b_din_rs1(b_din_rs1), .b_din_rs2(b_din_rs2), .b_din_rs3(b_din_rs3),
    .b_din_insn(b_din_insn),
    .b_dout_valid(b_dout_valid), .b_dout_ready(b_dout_ready), .b_dout_rd(b_dout_rd),
    .core_din_valid(core_din_valid), .core_din_ready(core_din_ready),
    .core_din_rs1(core_din_rs1), .core_din_rs2(core_din_rs2), .core_din_rs3(core_din_rs3),
    .core_din_insn(core_din_insn),
    .core_dout_valid(core_dout_valid), .core_dout_ready(core_dout_ready),
    .core_dout_rd(core_dout_rd),
    .err(err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state: queue of owner IDs in issue order (0=A, 1=B).
  int q[$];
  int m_prio   = 0;
  int m_lock   = -1;
  bit m_err    = 1'b0;
  int g_last   = -1;
  int last_pop = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rand_a();
    a_din_rs1 = {$urandom, $urandom}; a_din_rs2 = {$urandom, $urandom};
    a_din_rs3 = {$urandom, $urandom}; a_din_insn = $urandom;
  endtask

  task automatic rand_b();
    b_din_rs1 = {$urandom, $urandom}; b_din_rs2 = {$urandom, $urandom};
    b_din_rs3 = {$urandom, $urandom}; b_din_insn = $urandom;
  endtask

  task automatic set_idle();
    a_din_valid = 0; b_din_valid = 0; core_din_ready = 0;
    core_dout_valid = 0; a_dout_ready = 0; b_dout_ready = 0;
    core_dout_rd = {$urandom, $urandom};
  endtask

  // One clock: predict and compare outputs for the current inputs, then advance the model.
  task automatic tick();
    int sel, hd;
    bit full, sv, cv, arq, brq, ne, adv, bdv, cdr, issue, pop;
    #1;
    if (!resetn) begin
      chk("rst_ctrl", {a_din_ready, b_din_ready, a_dout_valid, b_dout_valid,
                       core_din_valid, core_dout_ready, err}, 64'd0);
      chk("rst_data", a_dout_rd | b_dout_rd | core_din_rs1 | core_din_rs2 | core_din_rs3, 64'd0);
      chk("rst_insn", core_din_insn, 64'd0);
      @(posedge clock);
      q.delete(); m_prio = 0; m_lock = -1; m_err = 0; g_last = -1; last_pop = -1;
      #1;
      return;
    end
    full = (q.size() == DEPTH);
    if (m_lock >= 0) sel = m_lock;
    else if (a_din_valid && !b_din_valid) sel = 0;
    else if (b_din_valid && !a_din_valid) sel = 1;
    else sel = m_prio;
    sv  = (sel == 1) ? b_din_valid : a_din_valid;
    cv  = sv && !full;
    arq = (sel == 0) && core_din_ready && !full;
    brq = (sel == 1) && core_din_ready && !full;
    ne  = (q.size() > 0);
    hd  = ne ? q[0] : 0;
    adv = ne && (hd == 0) && core_dout_valid;
    bdv = ne && (hd == 1) && core_dout_valid;
    cdr = ne && ((hd == 1) ? b_dout_ready : a_dout_ready);

    chk("core_din_valid", core_din_valid, cv);
    if (a_din_valid || b_din_valid || m_lock >= 0) begin
      chk("a_din_ready", a_din_ready, arq);
      chk("b_din_ready", b_din_ready, brq);
    end
    if (cv) begin
      chk("core_rs1", core_din_rs1, (sel == 1) ? b_din_rs1 : a_din_rs1);
      chk("core_rs2", core_din_rs2, (sel == 1) ? b_din_rs2 : a_din_rs2);
      chk("core_rs3", core_din_rs3, (sel == 1) ? b_din_rs3 : a_din_rs3);
      chk("core_insn", core_din_insn, (sel == 1) ? b_din_insn : a_din_insn);
    end
    chk("a_dout_valid", a_dout_valid, adv);
    chk("b_dout_valid", b_dout_valid, bdv);
    chk("core_dout_ready", core_dout_ready, cdr);
    chk("a_dout_rd", a_dout_rd, core_dout_rd);
    chk("b_dout_rd", b_dout_rd, core_dout_rd);
    chk("err", err, m_err);

    issue = cv && core_din_ready;
    pop   = core_dout_valid && cdr;
    @(posedge clock);
    if (!ne && core_dout_valid) m_err = 1;
    last_pop = pop ? hd : -1;
    if (pop) void'(q.pop_front());
    if (issue) begin
      q.push_back(sel);
      m_prio = 1 - sel;
      m_lock = -1;
    end else if (cv) begin
      m_lock = sel;
    end
    g_last = issue ? sel : -1;
    #1;
  endtask

  task automatic drain();
    set_idle();
    a_dout_ready = 1; b_dout_ready = 1;
    for (int i = 0; i < 3 * DEPTH && q.size() > 0; i++) begin
      core_dout_valid = 1;
      core_dout_rd = {$urandom, $urandom};
      tick();
    end
    chk("drain_empty", q.size(), 0);
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    rand_a(); rand_b();
    @(posedge clock); #1;

    // Reset: outputs low even with active inputs.
    resetn = 0;
    a_din_valid = 1; b_din_valid = 1; core_din_ready = 1; core_dout_valid = 1;
    a_dout_ready = 1; b_dout_ready = 1;
    tick(); tick();
    resetn = 1;
    set_idle();
    tick();

    // Alternating grants with immediate returns.
    for (int i = 0; i < 8; i++) begin
      a_din_valid = 1; b_din_valid = 1; core_din_ready = 1;
      a_dout_ready = 1; b_dout_ready = 1;
      rand_a(); rand_b();
      core_dout_valid = (q.size() > 0);
      core_dout_rd = {$urandom, $urandom};
      tick();
      chk("alt_grant", g_last, i % 2);
      if (i > 0) chk("alt_route", last_pop, (i - 1) % 2);
    end
    drain();

    // Lock: B waits on a stalled core, A arrives meanwhile; B must stay selected.
    b_din_valid = 1; rand_b();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin a_din_valid = 1; rand_a(); end
      #1;
      chk("lock_insn", core_din_insn, b_din_insn);
      chk("lock_a_rdy", a_din_ready, 0);
      tick();
    end
    core_din_ready = 1;
    tick();
    chk("lock_grant_b", g_last, 1);
    b_din_valid = 0;
    tick();
    chk("next_grant_a", g_last, 0);
    drain();

    // Full: four issues with no returns, then one pop admits exactly one more.
    a_din_valid = 1; core_din_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      rand_a();
      tick();
      chk("fill_grant", g_last, 0);
    end
    b_din_valid = 1; rand_b();
    #1;
    chk("full_a_rdy", a_din_ready, 0);
    chk("full_b_rdy", b_din_ready, 0);
    tick();
    core_dout_valid = 1; a_dout_ready = 1; b_dout_ready = 1;
    tick();
    chk("full_pop_nopush", g_last, -1);
    core_dout_valid = 0;
    tick();
    chk("refill_one", (g_last >= 0), 1);
    tick();
    chk("full_again", g_last, -1);
    drain();

    // Simultaneous push and pop at two in flight.
    core_din_ready = 1;
    a_din_valid = 1; rand_a(); tick();
    a_din_valid = 0; b_din_valid = 1; rand_b(); tick();
    b_din_valid = 0; a_din_valid = 1; rand_a();
    core_dout_valid = 1; a_dout_ready = 1; b_dout_ready = 1;
    #1;
    chk("pp_head_a", a_dout_valid, 1);
    tick();
    chk("pp_push", g_last, 0);
    chk("pp_pop", last_pop, 0);
    a_din_valid = 0;
    #1;
    chk("pp_head_b", b_dout_valid, 1);
    tick();
    drain();

    // Randomized traffic honoring valid/ready hold rules.
    for (int i = 0; i < 500; i++) begin
      if (!a_din_valid || g_last == 0) begin
        a_din_valid = ($urandom_range(0, 2) != 0); rand_a();
      end
      if (!b_din_valid || g_last == 1) begin
        b_din_valid = ($urandom_range(0, 2) != 0); rand_b();
      end
      core_din_ready  = ($urandom_range(0, 3) != 0);
      core_dout_valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
      a_dout_ready    = ($urandom_range(0, 3) != 0);
      b_dout_ready    = ($urandom_range(0, 3) != 0);
      core_dout_rd    = {$urandom, $urandom};
      tick();
    end
    drain();

    // Reset mid-operation with three in flight.
    a_din_valid = 1; core_din_ready = 1;
    for (int i = 0; i < 3; i++) begin rand_a(); tick(); end
    b_din_valid = 1; core_dout_valid = 1; a_dout_ready = 1;
    resetn = 0;
    tick();
    resetn = 1;
    core_dout_valid = 0;
    a_din_valid = 1; b_din_valid = 1; rand_a(); rand_b();
    tick();
    chk("post_rst_grant", g_last, 0);
    drain();

    // Result with nothing in flight raises a sticky error.
    set_idle();
    core_dout_valid = 1; a_dout_ready = 1; b_dout_ready = 1;
    #1;
    chk("err_cdr", core_dout_ready, 0);
    tick();
    core_dout_valid = 0;
    tick(); tick();
    #1;
    chk("err_sticky", err, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
